// File: rtl/fetch_queue.sv
// fetch_queue: in-order pc/instr buffer between fetch and decode, flushable on redirect
module fetch_queue #(
  parameter int DBITS = 32,
  parameter int DEPTH = 4,
  parameter logic [DBITS-1:0] NOP_INSTR = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DBITS-1:0]         in_pc,
  input  logic [DBITS-1:0]         in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DBITS-1:0]         out_pc,
  output logic [DBITS-1:0]         out_pcPlus4,
  output logic [DBITS-1:0]         out_instr,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [DBITS-1:0] pcs [DEPTH];
  logic [DBITS-1:0] instrs [DEPTH];
  logic [AW-1:0] head, tail;
  logic push, pop;
  always_comb begin
    in_ready = count != CW'(DEPTH);
    out_valid = count != '0;
    push = in_valid & in_ready & ~flush;
    pop = out_valid & out_ready & ~flush;
    out_pc = pcs[head];
    out_pcPlus4 = pcs[head] + DBITS'(4);
    out_instr = out_valid ? instrs[head] : NOP_INSTR;
  end
  always_ff @(posedge clk) begin
    if (push) begin
      pcs[tail] <= in_pc;
      instrs[tail] <= in_instr;
    end
  end
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop) head <= head + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: random and directed traffic checked against a queue-based model
module tb_fetch_queue;
  localparam int DBITS = 32;
  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 0;
  logic reset = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_pc = 0, in_instr = 0;
  logic in_ready, out_valid;
  logic [31:0] out_pc, out_pcPlus4, out_instr;
  logic [2:0] count;
  int compared = 0, mismatched = 0;
  bit chk_en = 0;
  logic [63:0] q [$];
  fetch_queue #(.DBITS(DBITS), .DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_pcPlus4(out_pcPlus4), .out_instr(out_instr), .count(count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    if (reset || flush) q.delete();
    else begin
      automatic bit pp = out_ready && q.size() > 0;
      automatic bit pu = in_valid && q.size() < DEPTH;
      if (pp) void'(q.pop_front());
      if (pu) q.push_back({in_pc, in_instr});
    end
  end
  always @(negedge clk) begin
    if (chk_en) begin
      chk("count", 32'(count), 32'(q.size()));
      chk("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        chk("out_pc", out_pc, q[0][63:32]);
        chk("out_pcPlus4", out_pcPlus4, q[0][63:32] + 32'd4);
        chk("out_instr", out_instr, q[0][31:0]);
      end else chk("out_instr_nop", out_instr, NOP);
    end
  end
  task automatic drive(input bit v, input logic [31:0] pc, input bit ordy, input bit fl, input bit rst);
    in_valid = v;
    in_pc = pc;
    in_instr = $urandom;
    out_ready = ordy;
    flush = fl;
    reset = rst;
    @(posedge clk);
    #1;
  endtask
  initial begin
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0);
    chk_en = 1;
    chk("rst_count", 32'(count), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_instr", out_instr, NOP);
    drive(1, 32'h40, 1, 0, 0);
    chk("s0_valid", 32'(out_valid), 1);
    chk("s0_pc", out_pc, 32'h40);
    chk("s0_pc4", out_pcPlus4, 32'h44);
    drive(1, 32'h44, 1, 0, 0);
    chk("s1_pc", out_pc, 32'h44);
    chk("s1_count", 32'(count), 1);
    drive(1, 32'h48, 1, 0, 0);
    chk("s2_pc", out_pc, 32'h48);
    chk("s2_pc4", out_pcPlus4, 32'h4C);
    drive(0, 0, 1, 0, 0);
    chk("s3_empty", 32'(count), 0);
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h40 + 32'(4 * i), 0, 0, 0);
      if (i == 3) chk("fill_ready", 32'(in_ready), 0);
    end
    chk("full_count", 32'(count), 4);
    chk("full_head", out_pc, 32'h40);
    drive(1, 32'h60, 1, 0, 0);
    chk("fullpop_count", 32'(count), 3);
    chk("fullpop_ready", 32'(in_ready), 1);
    chk("fullpop_head", out_pc, 32'h44);
    drive(1, 32'h60, 0, 0, 0);
    chk("refill_count", 32'(count), 4);
    drive(0, 0, 1, 0, 0);
    chk("pre_flush", 32'(count), 3);
    drive(1, 32'h200, 1, 1, 0);
    chk("flush_count", 32'(count), 0);
    chk("flush_valid", 32'(out_valid), 0);
    chk("flush_nop", out_instr, NOP);
    drive(1, 32'h100, 0, 0, 0);
    chk("post_flush_pc", out_pc, 32'h100);
    drive(1, 32'h104, 0, 0, 0);
    chk("pre_rst", 32'(count), 2);
    drive(1, 32'h300, 0, 0, 1);
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_ready", 32'(in_ready), 1);
    chk("mid_rst_valid", 32'(out_valid), 0);
    drive(0, 0, 1, 0, 0);
    chk("mid_rst_retained", 32'(count), 0);
    drive(1, 32'hFFFF_FFFC, 0, 0, 0);
    chk("wrap_pc4", out_pcPlus4, 32'h0);
    for (int i = 0; i < 600; i++)
      drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1) != 0,
            $urandom_range(0, 40) == 0, $urandom_range(0, 80) == 0);
    drive(0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Decoupling buffer between instruction fetch (PC register plus instruction memory) and decode.
- Captures (pc, instr) pairs produced each fetch cycle and presents them in order to decode using a valid/ready handshake.
- Absorbs decode stalls without back-pressuring the fetch path combinationally.
- Discards all buffered entries on a branch/jump redirect (flush).

Parameters:
- DBITS, 32, width of PC and instruction words.
- DEPTH, 4, number of entries; power of two, minimum 2.
- NOP_INSTR, 32'h0, value driven on out_instr when out_valid is low.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears queue.
- flush  input  1  redirect; discard all entries at the next edge.
- in_valid  input  1  fetch presents a valid pair this cycle.
- in_ready  output  1  queue can accept a pair (not full).
- in_pc  input  DBITS  PC of the fetched instruction.
- in_instr  input  DBITS  fetched instruction word.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  decode consumes head this cycle.
- out_pc  output  DBITS  PC of head entry.
- out_pcPlus4  output  DBITS  out_pc + 4, modulo 2^DBITS.
- out_instr  output  DBITS  head instruction, or NOP_INSTR when empty.
- count  output  clog2(DEPTH)+1  number of valid entries.

Behaviour:
- Storage: DEPTH-entry register array; read pointer, write pointer, and count, each clog2(DEPTH) bits except count. Pointers wrap modulo DEPTH.
- Reset, sampled at the rising edge when reset=1:
  - pointers=0, count=0, out_valid=0, in_ready=1.
  - out_instr=NOP_INSTR; out_pc and out_pcPlus4 are don't-care.
  - Reset overrides flush, push, and pop in the same cycle.
- Combinational outputs:
  - in_ready = (count != DEPTH). It depends only on registered state; there is no combinational path from out_ready.
  - out_valid = (count != 0).
  - out_pc and out_instr come from the read-pointer entry; out_instr is forced to NOP_INSTR when out_valid=0.
- push = in_valid & in_ready & ~flush. Entry is written at the write pointer; write pointer increments.
- pop = out_valid & out_ready & ~flush. Read pointer increments.
- Count update: push and pop together leaves count unchanged; push only gives +1; pop only gives −1.
- Latency: a pair pushed at edge N is visible on out_* after edge N, i.e. one cycle minimum. There is no bypass from in_* to out_*.
- Full: in_ready=0, even if decode pops in the same cycle; the freed slot is usable next cycle. in_valid while full is ignored and fetch holds its PC.
- Empty: out_valid=0; out_ready is ignored.
- Flush:
  - At the next edge: count=0, read pointer = write pointer = 0.
  - Any push or pop requested in the flush cycle is dropped.
  - The first post-redirect pair may be pushed in the cycle after flush.
- Reset mid-operation behaves identically to flush and also re-establishes all reset values.
- Stored data is not cleared on flush or reset; validity is governed solely by count.
- out_pcPlus4 wraps: 32'hFFFFFFFC gives 32'h0.

Test Plan:
- Reset then stream: reset 1 cycle; push pc 0x40, 0x44, 0x48 with out_ready=1 → out_valid first high the cycle after the 0x40 push; out_pc sequence 0x40, 0x44, 0x48; out_pcPlus4 sequence 0x44, 0x48, 0x4C; count never exceeds 1.
- Fill to full: out_ready=0; push 5 pairs with DEPTH=4 → count=4, in_ready=0 after the 4th push; 5th pair not stored; out_pc stays 0x40.
- Full with simultaneous pop: state full, in_valid=1, out_ready=1 → pop occurs, push rejected, count=3; next cycle in_ready=1 and the push succeeds, count=4.
- Wrap-around: 10 push/pop cycles with DEPTH=4 and random out_ready → FIFO order preserved across pointer wrap; count matches a reference model every cycle.
- Flush with traffic: count=3; assert flush together with in_valid=1 and out_ready=1 → next cycle count=0, out_valid=0, out_instr=NOP_INSTR; pushing pc 0x100 the following cycle → out_pc=0x100 one cycle later.
- Reset mid-operation: count=2; assert reset together with flush=0 and in_valid=1 → next cycle count=0, in_ready=1, out_valid=0; pushed data not retained.
